// File: rtl/nf_ram_dma.sv
// Copy/fill DMA engine driving a single-port, combinational-read RAM.
// Copy alternates RD/WR (1 word per 2 cycles); fill streams WR (1 word per cycle).
module nf_ram_dma #(
   parameter int len_w = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [len_w-1:0] length,
   input  logic [31:0]      fill_data,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic [len_w-1:0] count,
   output logic [31:0]      ram_addr,
   output logic             ram_we,
   output logic [31:0]      ram_wd,
   input  logic [31:0]      ram_rd
);

   typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             mode_q, mode_d;
   logic [31:0]      src_q, src_d, dst_q, dst_d;
   logic [31:0]      data_q, data_d, fill_q, fill_d;
   logic [len_w-1:0] rem_q, rem_d, cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         mode_q  <= 1'b0;
         src_q   <= '0;
         dst_q   <= '0;
         data_q  <= '0;
         fill_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      mode_d  = mode_q;
      src_d   = src_q;
      dst_d   = dst_q;
      data_d  = data_q;
      fill_d  = fill_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               mode_d = mode;
               src_d  = src_addr;
               dst_d  = dst_addr;
               rem_d  = length;
               fill_d = fill_data;
               cnt_d  = '0;
               if (length == '0) state_d = S_DONE;
               else if (mode)    state_d = S_WR;
               else              state_d = S_RD;
            end
         end
         S_RD: begin
            data_d  = ram_rd;
            state_d = abort ? S_DONE : S_WR;
         end
         S_WR: begin
            // The write in this cycle commits even when abort is sampled.
            src_d = src_q + 32'd1;
            dst_d = dst_q + 32'd1;
            cnt_d = cnt_q + len_w'(1);
            rem_d = rem_q - len_w'(1);
            if (abort || rem_q == len_w'(1)) state_d = S_DONE;
            else if (mode_q)                 state_d = S_WR;
            else                             state_d = S_RD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
      ram_we   = (state_q == S_WR);
      ram_addr = '0;
      ram_wd   = '0;
      if (state_q == S_RD) ram_addr = src_q;
      if (state_q == S_WR) begin
         ram_addr = dst_q;
         ram_wd   = mode_q ? fill_q : data_q;
      end
   end

   assign count = cnt_q;

endmodule

// File: tb/tb_nf_ram_dma.sv
// Bench for nf_ram_dma: directed vector table, reset-mid-transfer sequence,
// and randomized transfers checked cycle by cycle against a word-level model.
module tb_nf_ram_dma;

   logic        clk = 1'b0;
   logic        rst, start, mode, abort;
   logic [31:0] src_addr, dst_addr, fill_data;
   logic [15:0] length;
   logic        busy, done, ram_we;
   logic [15:0] count;
   logic [31:0] ram_addr, ram_wd, ram_rd;

   logic [31:0] mem [64];
   logic [31:0] mdl [64];

   int n_pass = 0;
   int n_tot  = 0;

   typedef struct {
      string       nm;
      bit          mode;
      logic [31:0] src, dst, fill;
      int          len, abort_k;
      bit          ign;
      int          exp_done, exp_cnt;
   } vec_t;

   nf_ram_dma #(.len_w(16)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode),
      .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
      .fill_data(fill_data), .abort(abort), .busy(busy), .done(done),
      .count(count), .ram_addr(ram_addr), .ram_we(ram_we),
      .ram_wd(ram_wd), .ram_rd(ram_rd)
   );

   always #5 clk = ~clk;

   assign ram_rd = mem[ram_addr[5:0]];
   always @(posedge clk) if (ram_we) mem[ram_addr[5:0]] <= ram_wd;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   task automatic chk_mem(input string nm);
      int bad = 0;
      for (int i = 0; i < 64; i++) if (mem[i] !== mdl[i]) bad++;
      chk({nm, " mem"}, bad, 0);
   endtask

   // Word-level rules: words moved, then timing from start.
   function automatic int eff_len(input int len, input int k);
      return (k > 0) ? k : len;
   endfunction
   function automatic int done_cyc(input bit m, input int len, input int k);
      int n = eff_len(len, k);
      if (n == 0) return 1;
      return m ? n + 1 : 2 * n + 1;
   endfunction

   task automatic run(input vec_t v);
      logic [31:0] exp_wd [$];
      logic [31:0] w;
      int neff, dc, wr, rd;
      neff = eff_len(v.len, v.abort_k);
      dc   = v.exp_done;
      for (int i = 0; i < neff; i++) begin
         w = v.mode ? v.fill : mdl[6'(v.src + 32'(i))];
         mdl[6'(v.dst + 32'(i))] = w;
         exp_wd.push_back(w);
      end
      @(negedge clk);
      mode = v.mode; src_addr = v.src; dst_addr = v.dst;
      length = 16'(v.len); fill_data = v.fill; start = 1'b1;
      for (int c = 1; c <= dc + 1; c++) begin
         @(negedge clk);
         wr = -1; rd = -1;
         if (v.mode) begin
            if (c <= neff) wr = c - 1;
         end else if (c <= 2 * neff) begin
            if (c % 2 == 0) wr = c / 2 - 1;
            else            rd = (c - 1) / 2;
         end
         chk({v.nm, " we"}, ram_we, wr >= 0);
         if (wr >= 0) begin
            chk({v.nm, " wr addr"}, ram_addr, v.dst + 32'(wr));
            chk({v.nm, " wd"}, ram_wd, exp_wd[wr]);
         end
         if (rd >= 0) chk({v.nm, " rd addr"}, ram_addr, v.src + 32'(rd));
         chk({v.nm, " done"}, done, c == dc);
         chk({v.nm, " busy"}, busy, c <= dc);
         if (c >= dc) chk({v.nm, " count"}, count, v.exp_cnt);
         start = v.ign && c <= dc && (c == 2 || c == dc);
         abort = (v.abort_k > 0) && (wr == v.abort_k - 1);
         if (start) begin
            mode = ~v.mode; length = 16'd7; dst_addr = 32'd40;
         end
      end
      start = 1'b0; abort = 1'b0;
      chk_mem(v.nm);
   endtask

   vec_t tbl [$];
   vec_t rv;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; abort = 1'b0;
      src_addr = '0; dst_addr = '0; fill_data = '0; length = '0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h5A00_0000 + 32'(i);
         mdl[i] = mem[i];
      end
      mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
      for (int i = 0; i < 4; i++) mdl[i] = mem[i];

      repeat (3) @(negedge clk);
      chk("rst busy", busy, 0);
      chk("rst done", done, 0);
      chk("rst we", ram_we, 0);
      chk("rst addr", ram_addr, 0);
      chk("rst wd", ram_wd, 0);
      chk("rst count", count, 0);
      rst = 1'b0;

      tbl.push_back('{"copy4",  1'b0, 32'd0, 32'd8,        32'd0,         4,  0, 1'b0, 9, 4});
      tbl.push_back('{"fill5",  1'b1, 32'd0, 32'd16,       32'hDEADBEEF,  5,  0, 1'b0, 6, 5});
      tbl.push_back('{"zero_c", 1'b0, 32'd0, 32'd24,       32'd0,         0,  0, 1'b0, 1, 0});
      tbl.push_back('{"zero_f", 1'b1, 32'd0, 32'd24,       32'h1234,      0,  0, 1'b1, 1, 0});
      tbl.push_back('{"abort_f",1'b1, 32'd0, 32'd48,       32'hCAFE0001, 10,  3, 1'b1, 4, 3});
      tbl.push_back('{"wrap",   1'b0, 32'd4, 32'hFFFFFFFF, 32'd0,         2,  0, 1'b0, 5, 2});
      tbl.push_back('{"abort_c",1'b0, 32'd8, 32'd40,       32'd0,         5,  2, 1'b1, 5, 2});
      tbl.push_back('{"overlap",1'b0, 32'd0, 32'd1,        32'd0,         3,  0, 1'b0, 7, 3});
      foreach (tbl[i]) run(tbl[i]);

      // Reset during the second RD of a four-word copy.
      @(negedge clk);
      mode = 1'b0; src_addr = 32'd0; dst_addr = 32'd32; length = 16'd4; start = 1'b1;
      @(negedge clk); start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("mid rd addr", ram_addr, 32'd1);
      rst = 1'b1;
      mdl[32] = mdl[0];
      @(negedge clk);
      chk("mid busy", busy, 0);
      chk("mid we", ram_we, 0);
      chk("mid count", count, 0);
      chk("mid done", done, 0);
      chk("mid addr", ram_addr, 0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("mid idle we", ram_we, 0);
      end
      chk_mem("mid");
      run('{"post_rst", 1'b1, 32'd0, 32'd32, 32'hA5A5A5A5, 3, 0, 1'b0, 4, 3});

      for (int n = 0; n < 40; n++) begin
         rv.nm   = "rand";
         rv.mode = 1'($urandom);
         rv.src  = $urandom;
         rv.dst  = $urandom;
         rv.fill = $urandom;
         rv.len  = int'($urandom_range(0, 8));
         rv.abort_k = (rv.len > 0 && $urandom_range(0, 2) == 0) ?
                      int'($urandom_range(1, rv.len)) : 0;
         rv.ign  = 1'($urandom);
         rv.exp_done = done_cyc(rv.mode, rv.len, rv.abort_k);
         rv.exp_cnt  = eff_len(rv.len, rv.abort_k);
         run(rv);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
